gpio_cmd_regfile: RTL and testbench

- Command decoder and register file between the soft processor's 32-bit GPO/GPI pair and the datapath: Tx/Rx, filter phase, BRAM logger and BER counters.
- Parametrised successor of the fixed I/Q command interface:
  - N_CH BER channels, selected by index.
  - Coherent multi-channel BER snapshots.
  - BRAM read with configurable latency and a busy/ack handshake.
  - Error and overrun flagging.

---
 rtl/gpio_cmd_pkg.sv | 37 +++
 rtl/gpio_cmd_regfile_edge_strobe.sv | 35 +++
 rtl/gpio_cmd_regfile.sv | 222 ++++++++++++++++++++++
 tb/tb_gpio_cmd_regfile.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_cmd_pkg.sv
// Command codes, GPO field helpers and FSM state encoding shared by the
// gpio_cmd_regfile slice.
package gpio_cmd_pkg;

  localparam int CMD_W = 8;
  localparam int CNT_W = 8;

  localparam logic [CMD_W-1:0] CMD_RESET       = 8'd0;
  localparam logic [CMD_W-1:0] CMD_EN_TX       = 8'd1;
  localparam logic [CMD_W-1:0] CMD_EN_RX       = 8'd2;
  localparam logic [CMD_W-1:0] CMD_PH_SEL      = 8'd3;
  localparam logic [CMD_W-1:0] CMD_RUN_MEM     = 8'd4;
  localparam logic [CMD_W-1:0] CMD_READ_MEM    = 8'd5;
  localparam logic [CMD_W-1:0] CMD_ADDR_MEM    = 8'd6;
  localparam logic [CMD_W-1:0] CMD_BER_SNAP    = 8'd7;
  localparam logic [CMD_W-1:0] CMD_BER_S       = 8'd8;
  localparam logic [CMD_W-1:0] CMD_BER_E       = 8'd9;
  // code 10 is reserved and decodes as an unknown command
  localparam logic [CMD_W-1:0] CMD_BER_H       = 8'd11;
  localparam logic [CMD_W-1:0] CMD_IS_MEM_FULL = 8'd12;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_MEM  = 2'd1,
    ST_RST_PULSE = 2'd2
  } state_t;

  // Enable bit sits just below the command byte; data fills the rest.
  function automatic int en_pos(input int nb_gpio);
    return nb_gpio - CMD_W - 1;
  endfunction

  function automatic int data_w(input int nb_gpio);
    return nb_gpio - CMD_W - 1;
  endfunction

endpackage

// File: rtl/gpio_cmd_regfile_edge_strobe.sv
// GPO register stage with rising-edge detect on the enable bit; cmd/data are
// taken from the registered word so they are stable in the strobe cycle.
module gpio_edge_strobe
  import gpio_cmd_pkg::*;
#(
  parameter int NB_GPIO = 32
) (
  input  logic                       i_clock,
  input  logic                       i_reset,
  input  logic [NB_GPIO-1:0]         i_gpo,
  output logic                       o_strobe,
  output logic [CMD_W-1:0]           o_cmd,
  output logic [data_w(NB_GPIO)-1:0] o_data
);

  localparam int EN_POS = en_pos(NB_GPIO);

  logic [NB_GPIO-1:0] gpo_q;
  logic               en_prev;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      gpo_q   <= '0;
      en_prev <= 1'b0;
    end else begin
      gpo_q   <= i_gpo;
      en_prev <= gpo_q[EN_POS];
    end
  end

  assign o_strobe = gpo_q[EN_POS] & ~en_prev;
  assign o_cmd    = gpo_q[NB_GPIO-1 -: CMD_W];
  assign o_data   = gpo_q[EN_POS-1:0];

endmodule

// File: rtl/gpio_cmd_regfile.sv
// Command decoder and register file between the soft-processor GPO/GPI pair
// and the Tx/Rx, filter-phase, BRAM-logger and BER-counter datapath.
//
// state        | meaning
// -------------+-----------------------------------------------------------
// ST_IDLE      | accepting commands on the enable strobe
// ST_WAIT_MEM  | BRAM address issued, down-counting read latency (busy)
// ST_RST_PULSE | soft reset asserted, down-counting pulse length (busy)
module gpio_cmd_regfile
  import gpio_cmd_pkg::*;
#(
  parameter int NB_GPIO         = 32,
  parameter int N_CH            = 2,
  parameter int NB_BER          = 64,
  parameter int NB_PHASE        = 2,
  parameter int BRAM_ADDR_WIDTH = 15,
  parameter int BRAM_DATA_WIDTH = 16,
  parameter int MEM_LAT         = 2,
  parameter int RST_LEN         = 4
) (
  input  logic                       i_clock,
  input  logic                       i_reset,
  input  logic [NB_GPIO-1:0]         i_gpo,
  output logic [NB_GPIO-1:0]         o_gpi,
  output logic                       o_rst,
  output logic                       o_enb_tx,
  output logic                       o_enb_rx,
  output logic [NB_PHASE-1:0]        o_phase_sel,
  output logic                       o_run_log,
  output logic                       o_read_log,
  output logic [BRAM_ADDR_WIDTH-1:0] o_addr_log,
  input  logic                       i_mem_full,
  input  logic [BRAM_DATA_WIDTH-1:0] i_data_log,
  input  logic [N_CH*NB_BER-1:0]     i_ber_samples,
  input  logic [N_CH*NB_BER-1:0]     i_ber_errors,
  output logic                       o_busy,
  output logic                       o_ack,
  output logic                       o_cmd_err,
  output logic                       o_overrun
);

  localparam int DW = data_w(NB_GPIO);

  logic           strobe;
  logic [CMD_W-1:0] cmd;
  logic [DW-1:0]  data;

  state_t                     state, state_nx;
  logic [CNT_W-1:0]           cnt, cnt_nx;
  logic [NB_GPIO-1:0]         gpi_nx, high_r, high_nx;
  logic                       ack_nx, rst_nx, enb_tx_nx, enb_rx_nx;
  logic                       run_log_nx, read_log_nx, cmd_err_nx, overrun_nx;
  logic [NB_PHASE-1:0]        phase_nx;
  logic [BRAM_ADDR_WIDTH-1:0] addr_nx;
  logic [N_CH*NB_BER-1:0]     snap_s, snap_e, snap_s_nx, snap_e_nx;

  logic [2:0]        ch;
  logic              ch_ok;
  logic [NB_BER-1:0] sel;
  logic              unused_data;

  gpio_edge_strobe #(.NB_GPIO(NB_GPIO)) u_edge (
    .i_clock  (i_clock),
    .i_reset  (i_reset),
    .i_gpo    (i_gpo),
    .o_strobe (strobe),
    .o_cmd    (cmd),
    .o_data   (data)
  );

  // Upper data bits beyond the address field carry no meaning.
  assign unused_data = ^data;
  assign ch          = data[2:0];

  // Channel select through a loop keeps out-of-range indices from ever
  // addressing past the packed snapshot vectors.
  always_comb begin
    ch_ok = 1'b0;
    sel   = '0;
    for (int c = 0; c < N_CH; c++) begin
      if (ch == 3'(c)) begin
        ch_ok = 1'b1;
        sel   = (cmd == CMD_BER_E) ? snap_e[c*NB_BER +: NB_BER]
                                   : snap_s[c*NB_BER +: NB_BER];
      end
    end
  end

  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    gpi_nx      = o_gpi;
    high_nx     = high_r;
    ack_nx      = o_ack;
    rst_nx      = o_rst;
    enb_tx_nx   = o_enb_tx;
    enb_rx_nx   = o_enb_rx;
    phase_nx    = o_phase_sel;
    run_log_nx  = 1'b0;
    read_log_nx = o_read_log;
    addr_nx     = o_addr_log;
    cmd_err_nx  = o_cmd_err;
    overrun_nx  = o_overrun;
    snap_s_nx   = snap_s;
    snap_e_nx   = snap_e;

    case (state)
      ST_IDLE: begin
        if (strobe) begin
          case (cmd)
            CMD_RESET: begin
              rst_nx      = 1'b1;
              enb_tx_nx   = 1'b0;
              enb_rx_nx   = 1'b0;
              phase_nx    = '0;
              read_log_nx = 1'b0;
              cmd_err_nx  = 1'b0;
              overrun_nx  = 1'b0;
              cnt_nx      = CNT_W'(RST_LEN - 1);
              state_nx    = ST_RST_PULSE;
            end
            CMD_EN_TX:    enb_tx_nx   = data[0];
            CMD_EN_RX:    enb_rx_nx   = data[0];
            CMD_PH_SEL:   phase_nx    = data[NB_PHASE-1:0];
            CMD_RUN_MEM:  run_log_nx  = 1'b1;
            CMD_READ_MEM: read_log_nx = data[0];
            CMD_ADDR_MEM: begin
              addr_nx  = data[BRAM_ADDR_WIDTH-1:0];
              cnt_nx   = CNT_W'(MEM_LAT - 1);
              state_nx = ST_WAIT_MEM;
            end
            CMD_BER_SNAP: begin
              snap_s_nx = i_ber_samples;
              snap_e_nx = i_ber_errors;
              gpi_nx    = '0;
              ack_nx    = ~o_ack;
            end
            CMD_BER_S, CMD_BER_E: begin
              if (ch_ok) begin
                gpi_nx  = NB_GPIO'(sel[31:0]);
                high_nx = NB_GPIO'(sel[NB_BER-1:32]);
                ack_nx  = ~o_ack;
              end else begin
                cmd_err_nx = 1'b1;
              end
            end
            CMD_BER_H: begin
              gpi_nx = high_r;
              ack_nx = ~o_ack;
            end
            CMD_IS_MEM_FULL: begin
              gpi_nx = NB_GPIO'(i_mem_full);
              ack_nx = ~o_ack;
            end
            default: cmd_err_nx = 1'b1;
          endcase
        end
      end
      ST_WAIT_MEM: begin
        if (strobe) overrun_nx = 1'b1;
        if (cnt == '0) begin
          gpi_nx   = NB_GPIO'(i_data_log);
          ack_nx   = ~o_ack;
          state_nx = ST_IDLE;
        end else begin
          cnt_nx = cnt - 1'b1;
        end
      end
      ST_RST_PULSE: begin
        if (strobe) overrun_nx = 1'b1;
        if (cnt == '0) begin
          rst_nx   = 1'b0;
          state_nx = ST_IDLE;
        end else begin
          cnt_nx = cnt - 1'b1;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      o_gpi       <= '0;
      high_r      <= '0;
      o_ack       <= 1'b0;
      o_rst       <= 1'b0;
      o_enb_tx    <= 1'b0;
      o_enb_rx    <= 1'b0;
      o_phase_sel <= '0;
      o_run_log   <= 1'b0;
      o_read_log  <= 1'b0;
      o_addr_log  <= '0;
      o_cmd_err   <= 1'b0;
      o_overrun   <= 1'b0;
      snap_s      <= '0;
      snap_e      <= '0;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      o_gpi       <= gpi_nx;
      high_r      <= high_nx;
      o_ack       <= ack_nx;
      o_rst       <= rst_nx;
      o_enb_tx    <= enb_tx_nx;
      o_enb_rx    <= enb_rx_nx;
      o_phase_sel <= phase_nx;
      o_run_log   <= run_log_nx;
      o_read_log  <= read_log_nx;
      o_addr_log  <= addr_nx;
      o_cmd_err   <= cmd_err_nx;
      o_overrun   <= overrun_nx;
      snap_s      <= snap_s_nx;
      snap_e      <= snap_e_nx;
    end
  end

  assign o_busy = (state != ST_IDLE);

endmodule

// File: tb/tb_gpio_cmd_regfile.sv
// Directed and randomized bench for gpio_cmd_regfile against an edge-indexed
// behavioural model of the command interface.
module tb_gpio_cmd_regfile;

  localparam int NB_GPIO = 32;
  localparam int N_CH    = 2;
  localparam int NB_BER  = 64;
  localparam int NB_PH   = 2;
  localparam int AW      = 15;
  localparam int DW      = 16;
  localparam int MEM_LAT = 2;
  localparam int RST_LEN = 4;

  logic                   i_clock = 1'b0;
  logic                   i_reset = 1'b0;
  logic [NB_GPIO-1:0]     i_gpo = '0;
  logic [NB_GPIO-1:0]     o_gpi;
  logic                   o_rst, o_enb_tx, o_enb_rx, o_run_log, o_read_log;
  logic [NB_PH-1:0]       o_phase_sel;
  logic [AW-1:0]          o_addr_log;
  logic                   i_mem_full = 1'b0;
  logic [DW-1:0]          i_data_log = '0;
  logic [N_CH*NB_BER-1:0] i_ber_samples = '0;
  logic [N_CH*NB_BER-1:0] i_ber_errors = '0;
  logic                   o_busy, o_ack, o_cmd_err, o_overrun;

  gpio_cmd_regfile #(
    .NB_GPIO(NB_GPIO), .N_CH(N_CH), .NB_BER(NB_BER), .NB_PHASE(NB_PH),
    .BRAM_ADDR_WIDTH(AW), .BRAM_DATA_WIDTH(DW), .MEM_LAT(MEM_LAT), .RST_LEN(RST_LEN)
  ) dut (
    .i_clock(i_clock), .i_reset(i_reset), .i_gpo(i_gpo), .o_gpi(o_gpi),
    .o_rst(o_rst), .o_enb_tx(o_enb_tx), .o_enb_rx(o_enb_rx),
    .o_phase_sel(o_phase_sel), .o_run_log(o_run_log), .o_read_log(o_read_log),
    .o_addr_log(o_addr_log), .i_mem_full(i_mem_full), .i_data_log(i_data_log),
    .i_ber_samples(i_ber_samples), .i_ber_errors(i_ber_errors),
    .o_busy(o_busy), .o_ack(o_ack), .o_cmd_err(o_cmd_err), .o_overrun(o_overrun)
  );

  always #5 i_clock = ~i_clock;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a strobe at edge n exists when the word sampled at edge n-1 has
  // the enable bit set and the word sampled at edge n-2 does not. A busy
  // action started at edge n finishes at edge n+L; strobes up to and
  // including that edge are dropped.
  typedef enum int {P_NONE, P_MEM, P_RST} pend_t;

  bit           cmp_en = 0;
  int           edge_n = 0;
  pend_t        pend = P_NONE;
  int           pend_at = 0;
  logic [31:0]  prev1 = '0, prev2 = '0;
  logic [31:0]  m_gpi, m_high;
  logic         m_ack, m_rst, m_tx, m_rx, m_run, m_read, m_err, m_ovr;
  logic [1:0]   m_ph;
  logic [14:0]  m_addr;
  logic [63:0]  m_snap_s [N_CH];
  logic [63:0]  m_snap_e [N_CH];
  int           run_pulses = 0;

  task automatic exec(input logic [7:0] cm, input logic [22:0] d);
    logic [63:0] v;
    case (cm)
      8'd0: begin
        m_rst = 1; m_tx = 0; m_rx = 0; m_ph = 0; m_read = 0; m_err = 0; m_ovr = 0;
        pend = P_RST; pend_at = edge_n + RST_LEN;
      end
      8'd1: m_tx = d[0];
      8'd2: m_rx = d[0];
      8'd3: m_ph = d[1:0];
      8'd4: m_run = 1;
      8'd5: m_read = d[0];
      8'd6: begin m_addr = d[14:0]; pend = P_MEM; pend_at = edge_n + MEM_LAT; end
      8'd7: begin
        for (int c = 0; c < N_CH; c++) begin
          m_snap_s[c] = i_ber_samples[c*64 +: 64];
          m_snap_e[c] = i_ber_errors[c*64 +: 64];
        end
        m_gpi = 0; m_ack = ~m_ack;
      end
      8'd8, 8'd9: begin
        if (int'(d[2:0]) >= N_CH) m_err = 1;
        else begin
          v = (cm == 8'd8) ? m_snap_s[d[2:0]] : m_snap_e[d[2:0]];
          m_gpi = v[31:0]; m_high = v[63:32]; m_ack = ~m_ack;
        end
      end
      8'd11: begin m_gpi = m_high; m_ack = ~m_ack; end
      8'd12: begin m_gpi = {31'b0, i_mem_full}; m_ack = ~m_ack; end
      default: m_err = 1;
    endcase
  endtask

  task automatic model_step();
    bit busy_now;
    edge_n++;
    if (i_reset) begin
      m_gpi = 0; m_high = 0; m_ack = 0; m_rst = 0; m_tx = 0; m_rx = 0; m_run = 0;
      m_read = 0; m_err = 0; m_ovr = 0; m_ph = 0; m_addr = 0;
      for (int c = 0; c < N_CH; c++) begin m_snap_s[c] = 0; m_snap_e[c] = 0; end
      pend = P_NONE; prev1 = 0; prev2 = 0; cmp_en = 1;
      return;
    end
    m_run = 0;
    busy_now = (pend != P_NONE);
    if (busy_now && edge_n == pend_at) begin
      if (pend == P_MEM) begin m_gpi = {16'b0, i_data_log}; m_ack = ~m_ack; end
      else m_rst = 0;
      pend = P_NONE;
    end
    if (prev1[23] && !prev2[23]) begin
      if (busy_now) m_ovr = 1;
      else exec(prev1[31:24], prev1[22:0]);
    end
    prev2 = prev1;
    prev1 = i_gpo;
  endtask

  always @(negedge i_clock) begin
    if (cmp_en) begin
      check("gpi", o_gpi, m_gpi);
      check("ack", o_ack, m_ack);
      check("rst", o_rst, m_rst);
      check("enb_tx", o_enb_tx, m_tx);
      check("enb_rx", o_enb_rx, m_rx);
      check("phase_sel", o_phase_sel, m_ph);
      check("run_log", o_run_log, m_run);
      check("read_log", o_read_log, m_read);
      check("addr_log", o_addr_log, m_addr);
      check("busy", o_busy, pend != P_NONE);
      check("cmd_err", o_cmd_err, m_err);
      check("overrun", o_overrun, m_ovr);
      if (o_run_log === 1'b1) run_pulses++;
    end
  end

  task automatic cycle(input logic [31:0] w, input logic rst);
    i_gpo = w;
    i_reset = rst;
    @(posedge i_clock);
    model_step();
    @(negedge i_clock);
  endtask

  task automatic issue(input int cmd, input int data, input int hold);
    logic [31:0] w;
    w = {cmd[7:0], 1'b1, data[22:0]};
    for (int i = 0; i < hold; i++) cycle(w, 1'b0);
    w[23] = 1'b0;
    cycle(w, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(32'h0, 1'b0);
  endtask

  int rcount;
  int pulses0;
  logic [31:0] w;

  initial begin
    cycle(32'h0, 1'b1);
    cycle(32'h0, 1'b1);
    check("reset_gpi", o_gpi, 0);
    check("reset_ack", o_ack, 0);
    check("reset_busy", o_busy, 0);
    idle(2);

    issue(1, 1, 1);
    check("en_tx_lit", o_enb_tx, 1);
    issue(3, 2, 1);
    check("phase_lit", o_phase_sel, 2);

    pulses0 = run_pulses;
    issue(4, 0, 50);
    idle(2);
    check("held_one_strobe", run_pulses - pulses0, 1);

    // Cmd/data changes under a held enable must not issue anything.
    cycle({8'd1, 1'b1, 23'd1}, 1'b0);
    cycle({8'd1, 1'b1, 23'd0}, 1'b0);
    for (int i = 0; i < 3; i++) cycle({8'd3, 1'b1, 23'd3}, 1'b0);
    idle(2);
    check("held_tx_kept", o_enb_tx, 1);
    check("held_phase_kept", o_phase_sel, 2);

    i_ber_samples = {64'h0000_0012_3456_789A, 64'h0000_0001_1111_2222};
    i_ber_errors  = {64'h0000_0000_0000_0042, 64'h0000_0003_0000_0007};
    issue(7, 0, 1);
    check("snap_ack", o_ack, 1);
    i_ber_samples = {64'hFFFF_FFFF_FFFF_FFFF, 64'h0};
    issue(8, 1, 1);
    check("ber_s_lo", o_gpi, 32'h3456789A);
    issue(11, 0, 1);
    check("ber_h", o_gpi, 32'h00000012);
    check("ber_ack_twice", o_ack, 1);

    i_data_log = 16'hAF0F;
    issue(6, 23'h1234, 1);
    check("addr_lit", o_addr_log, 15'h1234);
    check("mem_busy1", o_busy, 1);
    idle(1);
    check("mem_busy2", o_busy, 1);
    idle(1);
    check("mem_busy_done", o_busy, 0);
    check("mem_data", o_gpi, 32'h0000AF0F);
    check("mem_ack", o_ack, 0);

    issue(0, 0, 1);
    rcount = 0;
    for (int i = 0; i < 20 && o_rst === 1'b1; i++) begin
      rcount++;
      idle(1);
    end
    check("rst_len", rcount, RST_LEN);
    check("rst_tx_clr", o_enb_tx, 0);
    check("rst_phase_clr", o_phase_sel, 0);
    issue(0, 0, 1);
    issue(1, 1, 1);
    check("overrun_set", o_overrun, 1);
    check("overrun_dropped", o_enb_tx, 0);
    idle(6);

    issue(13, 0, 1);
    check("unknown_err", o_cmd_err, 1);
    check("unknown_gpi_kept", o_gpi, 32'h0000AF0F);
    issue(0, 0, 1);
    idle(6);
    check("err_cleared", o_cmd_err, 0);
    issue(8, 5, 1);
    check("bad_ch_err", o_cmd_err, 1);

    issue(6, 7, 1);
    cycle(32'h0, 1'b1);
    check("midwait_busy", o_busy, 0);
    check("midwait_gpi", o_gpi, 0);
    check("midwait_ack", o_ack, 0);
    i_mem_full = 1'b1;
    idle(1);
    issue(12, 0, 1);
    check("mem_full", o_gpi, 32'h1);

    w = '0;
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 3) == 0) w[23] = ~w[23];
      if ($urandom_range(0, 2) == 0) begin
        w[31:24] = ($urandom_range(0, 15) == 0) ? 8'($urandom) : 8'($urandom_range(0, 13));
        w[22:0]  = 23'($urandom);
        if ($urandom_range(0, 1) == 0) w[2:0] = 3'($urandom_range(0, 2));
      end
      i_mem_full = 1'($urandom);
      i_data_log = 16'($urandom);
      if ($urandom_range(0, 6) == 0) begin
        i_ber_samples = {$urandom, $urandom, $urandom, $urandom};
        i_ber_errors  = {$urandom, $urandom, $urandom, $urandom};
      end
      cycle(w, ($urandom_range(0, 299) == 0));
    end
    idle(8);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
